// File: rtl/ser2par_loader_pkg.sv
// Shared definitions for the serial-to-parallel loader and its register stage.
`timescale 1ns/1ps
package ser2par_loader_pkg;

    localparam int unsigned DEFAULT_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/ser2par_loader_if.sv
// Frame request / serial data in, parallel word and load strobe out.
`timescale 1ns/1ps
interface ser2par_loader_if
    import ser2par_loader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             sdi;
    logic             msb_first;
    logic [WIDTH-1:0] D;
    logic             L;
    logic             busy;

    modport master (output start, output sdi, output msb_first,
                    input  D,     input  L,   input  busy);

    modport slave  (input  start, input  sdi, input  msb_first,
                    output D,     output L,   output busy);
endinterface

// File: rtl/ser2par_loader_shift_buf.sv
// WIDTH-bit shift buffer; word_c is the value the buffer takes on the next shift.
`timescale 1ns/1ps
module sp_shift_buf
    import ser2par_loader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             sdi,
    output logic [WIDTH-1:0] word_c
);

    logic [WIDTH-1:0] buf_q;

    // dir=1 shifts towards the MSB so the first bit ends up in the top position
    always_comb begin
        word_c = dir ? {buf_q[WIDTH-2:0], sdi} : {sdi, buf_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else if (clr) begin
            buf_q <= '0;
        end else if (shift_en) begin
            buf_q <= word_c;
        end
    end

endmodule

// File: rtl/ser2par_loader.sv
// Collects WIDTH serial bits into a word, presents it on D and pulses L for one cycle.
`timescale 1ns/1ps
module ser2par_loader
    import ser2par_loader_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    ser2par_loader_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic [WIDTH-1:0] d_q;
    logic             l_q;
    logic             busy_q;

    logic             clr_c;
    logic             shift_en_c;
    logic [WIDTH-1:0] word_c;

    // A start is only honoured outside SHIFT; it also clears the buffer for the new frame
    always_comb begin
        clr_c      = 1'b0;
        shift_en_c = 1'b0;
        if ((state_q == ST_IDLE) || (state_q == ST_LOAD)) begin
            clr_c = bus.start;
        end
        if (state_q == ST_SHIFT) begin
            shift_en_c = 1'b1;
        end
    end

    sp_shift_buf #(
        .WIDTH (WIDTH)
    ) u_shift_buf (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_c),
        .shift_en (shift_en_c),
        .dir      (dir_q),
        .sdi      (bus.sdi),
        .word_c   (word_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            d_q     <= '0;
            l_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    l_q    <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= ST_SHIFT;
                        dir_q   <= bus.msb_first;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Last bit: publish the word including the bit sampled on this edge
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q <= ST_LOAD;
                        d_q     <= word_c;
                        l_q     <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    l_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= ST_SHIFT;
                        dir_q   <= bus.msb_first;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    l_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.D    = d_q;
    assign bus.L    = l_q;
    assign bus.busy = busy_q;

endmodule
